// File: rtl/fetch_stage.sv
// IF-stage fetch unit: credit-limited pipelined instruction-memory requests,
// a small response FIFO, wrong-path response discard, and registered IF/ID outputs.
package common;
  localparam logic [1:0] C_PIPE  = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;
  localparam logic [1:0] C_JUMP  = 2'b11;
endpackage

module fetch_stage
  import common::*;
#(
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [DWIDTH-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        if_ctrl,
  input  logic [DWIDTH-1:0] jpc,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic [DWIDTH-1:0] id_pc,
  output logic [DWIDTH-1:0] id_inst,
  output logic              id_valid
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [DWIDTH-1:0] STEP = DWIDTH'(4);

  logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_n;
  logic [DWIDTH-1:0] resp_pc_q, resp_pc_n;
  logic [CW-1:0]     outst_q, outst_n;
  logic [CW-1:0]     drop_q, drop_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [AW-1:0]     rd_q, rd_n;
  logic [AW-1:0]     wr_q, wr_n;
  logic [DWIDTH-1:0] pc_mem_q [BUF_DEPTH];
  logic [DWIDTH-1:0] pc_mem_n [BUF_DEPTH];
  logic [DWIDTH-1:0] inst_mem_q [BUF_DEPTH];
  logic [DWIDTH-1:0] inst_mem_n [BUF_DEPTH];
  logic [DWIDTH-1:0] id_pc_n, id_inst_n;
  logic              id_valid_n;

  logic kill;
  logic credit_ok;
  logic accept;
  logic push;
  logic pop;
  logic [DWIDTH-1:0] kill_target;

  // Credit covers both in-flight requests and buffered words, so a response always has a slot.
  assign kill        = (if_ctrl == C_JUMP) || (if_ctrl == C_FLUSH);
  assign kill_target = (if_ctrl == C_JUMP) ? jpc : RESET_PC;
  assign credit_ok   = ((CW+1)'(outst_q) + (CW+1)'(cnt_q)) < (CW+1)'(BUF_DEPTH);
  assign imem_req    = !kill && credit_ok && rst_n;
  assign imem_addr   = fetch_pc_q;
  assign accept      = imem_req && imem_gnt;

  // Next-state logic for the request, response and ID sides.
  always_comb begin
    fetch_pc_n = fetch_pc_q;
    resp_pc_n  = resp_pc_q;
    outst_n    = outst_q;
    drop_n     = drop_q;
    cnt_n      = cnt_q;
    rd_n       = rd_q;
    wr_n       = wr_q;
    pc_mem_n   = pc_mem_q;
    inst_mem_n = inst_mem_q;
    id_pc_n    = id_pc;
    id_inst_n  = id_inst;
    id_valid_n = id_valid;
    push       = 1'b0;
    pop        = 1'b0;

    if (kill) begin
      // Everything still in flight is wrong-path; a response landing now is dropped too.
      fetch_pc_n = kill_target;
      resp_pc_n  = kill_target;
      outst_n    = outst_q - CW'(imem_rvalid);
      drop_n     = outst_q - CW'(imem_rvalid);
      cnt_n      = '0;
      rd_n       = '0;
      wr_n       = '0;
      id_valid_n = 1'b0;
    end else begin
      if (accept) begin
        fetch_pc_n = fetch_pc_q + STEP;
      end
      outst_n = outst_q + CW'(accept) - CW'(imem_rvalid);

      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_n = drop_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end

      if (push) begin
        pc_mem_n[wr_q]   = resp_pc_q;
        inst_mem_n[wr_q] = imem_rdata;
        wr_n             = wr_q + AW'(1);
        resp_pc_n        = resp_pc_q + STEP;
      end

      // Pop only words already resident: no same-cycle bypass to ID.
      if (if_ctrl == C_PIPE) begin
        if (cnt_q != '0) begin
          pop        = 1'b1;
          id_pc_n    = pc_mem_q[rd_q];
          id_inst_n  = inst_mem_q[rd_q];
          id_valid_n = 1'b1;
          rd_n       = rd_q + AW'(1);
        end else begin
          id_valid_n = 1'b0;
        end
      end

      cnt_n = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      pc_mem_q   <= '{default: '0};
      inst_mem_q <= '{default: '0};
      id_pc      <= '0;
      id_inst    <= '0;
      id_valid   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_n;
      resp_pc_q  <= resp_pc_n;
      outst_q    <= outst_n;
      drop_q     <= drop_n;
      cnt_q      <= cnt_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      pc_mem_q   <= pc_mem_n;
      inst_mem_q <= inst_mem_n;
      id_pc      <= id_pc_n;
      id_inst    <= id_inst_n;
      id_valid   <= id_valid_n;
    end
  end

  // Structural invariants of the credit scheme.
  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    ((CW+1)'(outst_q) + (CW+1)'(cnt_q)) <= (CW+1)'(BUF_DEPTH));
  a_drop : assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= outst_q);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-randomized in-order memory plus a
// program-order reference model of the fetch address and ID instruction stream.
module tb_fetch_stage;
  import common::*;

  localparam int unsigned DW = 32;
  localparam int unsigned BD = 2;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    if_ctrl;
  logic [DW-1:0] jpc;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic          id_valid;

  fetch_stage #(.DWIDTH(DW), .RESET_PC(RST_PC), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .if_ctrl(if_ctrl), .jpc(jpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Memory model: accepted addresses with their response cycle, in order.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;

  // Reference model of the correct-path program order.
  logic [31:0] model_fetch;
  logic [31:0] model_id;
  int          n_ids = 0;
  logic [31:0] last_new_pc;
  logic        last_req;
  logic        prev_v;
  logic [31:0] prev_pc, prev_inst;

  task automatic clear_model();
    pend_addr.delete();
    pend_due.delete();
    last_due    = cyc;
    model_fetch = RST_PC;
    model_id    = RST_PC;
    prev_v      = 1'b0;
    prev_pc     = 32'h0;
    prev_inst   = 32'h0;
  endtask

  // One clock cycle: drive, observe request side, clock, observe ID side.
  task automatic cycle(input logic [1:0] ctrl, input logic [31:0] tgt);
    logic kill, req_s, gnt_s, rv;
    logic [31:0] addr_s;
    int lat, due;
    kill     = (ctrl == C_JUMP) || (ctrl == C_FLUSH);
    if_ctrl  = ctrl;
    jpc      = tgt;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    rv       = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? (pend_addr[0] ^ KEY) : 32'($urandom);
    #1;
    req_s  = imem_req;
    addr_s = imem_addr;
    gnt_s  = imem_gnt;
    last_req = req_s;
    if (req_s === 1'b1) begin
      cmp_cnt++;
      if (addr_s !== model_fetch) begin
        err_cnt++;
        $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, addr_s, model_fetch);
      end
      cmp_cnt++;
      if (pend_addr.size() >= BD) begin
        err_cnt++;
        $display("FAIL credit cyc=%0d: req with %0d in flight, limit %0d", cyc, pend_addr.size(), BD);
      end
    end
    if (kill) begin
      cmp_cnt++;
      if (req_s !== 1'b0) begin
        err_cnt++;
        $display("FAIL kill_req cyc=%0d: imem_req=%b expected 0", cyc, req_s);
      end
    end
    @(posedge clk);
    #1;
    if (rv) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (req_s === 1'b1 && gnt_s) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(addr_s);
      pend_due.push_back(due);
      model_fetch = model_fetch + 32'd4;
    end
    if (kill) begin
      model_fetch = (ctrl == C_JUMP) ? tgt : RST_PC;
      model_id    = model_fetch;
      cmp_cnt++;
      if (id_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL kill_bubble cyc=%0d: id_valid=%b expected 0", cyc, id_valid);
      end
    end else if (ctrl == C_STALL) begin
      cmp_cnt++;
      if ({id_valid, id_pc, id_inst} !== {prev_v, prev_pc, prev_inst}) begin
        err_cnt++;
        $display("FAIL stall_hold cyc=%0d: got v=%b pc=%h inst=%h expected v=%b pc=%h inst=%h",
                 cyc, id_valid, id_pc, id_inst, prev_v, prev_pc, prev_inst);
      end
    end else if (id_valid === 1'b1) begin
      cmp_cnt++;
      if (id_pc !== model_id || id_inst !== (model_id ^ KEY)) begin
        err_cnt++;
        $display("FAIL id_stream cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                 cyc, id_pc, id_inst, model_id, model_id ^ KEY);
      end
      last_new_pc = id_pc;
      model_id    = model_id + 32'd4;
      n_ids++;
    end
    prev_v    = id_valid;
    prev_pc   = id_pc;
    prev_inst = id_inst;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    if_ctrl     = C_PIPE;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
  endtask

  task automatic run_pipe(input int want, input int budget, output bit ok);
    int start;
    start = n_ids;
    for (int i = 0; i < budget; i++) begin
      if (n_ids - start >= want) break;
      cycle(C_PIPE, 32'h0);
    end
    ok = (n_ids - start >= want);
  endtask

  task automatic test_reset();
    if_ctrl = C_PIPE; jpc = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({id_valid, id_pc, id_inst, imem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_outputs: v=%b pc=%h inst=%h req=%b expected all zero",
               id_valid, id_pc, id_inst, imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      err_cnt++;
      $display("FAIL reset_first_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RST_PC);
    end
    @(posedge clk);
    #1;
    clear_model();
  endtask

  task automatic test_pipe();
    bit ok;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    run_pipe(4, 40, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== 32'd12) begin
      err_cnt++;
      $display("FAIL pipe_fill: ok=%0d last pc=%h expected ok=1 pc=0000000c", ok, last_new_pc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] base;
    base = last_new_pc;
    for (int i = 0; i < 5; i++) cycle(C_STALL, 32'h0);
    cmp_cnt++;
    if (last_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_credit: imem_req=%b after 5 stall cycles, expected 0", last_req);
    end
    run_pipe(4, 40, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== base + 32'd16) begin
      err_cnt++;
      $display("FAIL stall_resume: ok=%0d last pc=%h expected %h", ok, last_new_pc, base + 32'd16);
    end
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    for (int i = 0; i < 30; i++) begin
      if (pend_addr.size() == 2 && n_ids >= 2) break;
      cycle(C_PIPE, 32'h0);
    end
    cycle(C_JUMP, 32'h100);
    run_pipe(1, 40, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== 32'h100) begin
      err_cnt++;
      $display("FAIL jump_target: ok=%0d first pc=%h expected 00000100", ok, last_new_pc);
    end
  endtask

  task automatic test_coincident_kill();
    bit ok, hit;
    lat_min = 2; lat_max = 4; gnt_pct = 100;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend_addr.size() >= 1 && pend_due[0] <= cyc && pend_addr.size() == 2) begin
        hit = 1'b1;
        break;
      end
      cycle(C_PIPE, 32'h0);
    end
    cycle(C_JUMP, 32'h200);
    run_pipe(3, 60, ok);
    cmp_cnt++;
    if (!hit || !ok || last_new_pc !== 32'h208) begin
      err_cnt++;
      $display("FAIL coincident_kill: hit=%0d ok=%0d last pc=%h expected 00000208", hit, ok, last_new_pc);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    for (int i = 0; i < 30; i++) begin
      if (pend_addr.size() == 2) break;
      cycle(C_PIPE, 32'h0);
    end
    cycle(C_JUMP, 32'h300);
    cycle(C_JUMP, 32'h400);
    run_pipe(2, 60, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== 32'h404) begin
      err_cnt++;
      $display("FAIL back_to_back_kill: ok=%0d last pc=%h expected 00000404", ok, last_new_pc);
    end
  endtask

  task automatic test_flush();
    bit ok;
    lat_min = 1; lat_max = 3; gnt_pct = 100;
    run_pipe(3, 40, ok);
    cycle(C_FLUSH, 32'hDEAD_BEE0);
    run_pipe(1, 40, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== RST_PC) begin
      err_cnt++;
      $display("FAIL flush_restart: ok=%0d first pc=%h expected %h", ok, last_new_pc, RST_PC);
    end
  endtask

  task automatic test_async_reset_wrap();
    bit ok;
    lat_min = 1; lat_max = 2; gnt_pct = 100;
    run_pipe(3, 40, ok);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({id_valid, id_pc, id_inst, imem_req} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      err_cnt++;
      $display("FAIL async_reset: v=%b pc=%h inst=%h req=%b expected all zero",
               id_valid, id_pc, id_inst, imem_req);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if_ctrl     = C_PIPE;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    run_pipe(1, 40, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== RST_PC) begin
      err_cnt++;
      $display("FAIL reset_resume: ok=%0d first pc=%h expected %h", ok, last_new_pc, RST_PC);
    end
    cycle(C_JUMP, 32'hFFFF_FFFC);
    run_pipe(3, 60, ok);
    cmp_cnt++;
    if (!ok || last_new_pc !== 32'h4) begin
      err_cnt++;
      $display("FAIL pc_wrap: ok=%0d last pc=%h expected 00000004", ok, last_new_pc);
    end
  endtask

  task automatic test_random();
    int start, r;
    logic [31:0] t;
    logic [1:0] c;
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    start = n_ids;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      t = $urandom;
      t[1:0] = 2'b00;
      c = (r < 70) ? C_PIPE : (r < 90) ? C_STALL : (r < 97) ? C_JUMP : C_FLUSH;
      cycle(c, t);
    end
    cmp_cnt++;
    if (n_ids - start < 10) begin
      err_cnt++;
      $display("FAIL random_progress: %0d instructions delivered, expected at least 10", n_ids - start);
    end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_stall();
    test_jump();
    test_coincident_kill();
    test_back_to_back();
    test_flush();
    test_async_reset_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
